// File: rtl/mdu_ctrl.sv
// rtl/mdu_ctrl.sv - multiply/divide unit control with HI/LO registers and stall generation
// The full result is computed at issue and committed after a fixed busy latency.
module mdu_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  E_MDUOp,
  input  logic [31:0] E_A,
  input  logic [31:0] E_B,
  input  logic        E_Cancel,
  input  logic        D_IsMDU,
  output logic        E_Busy,
  output logic        Stall_MDU,
  output logic [31:0] E_MDUOut,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MFHI  = 4'd7;
  localparam logic [3:0] OP_MFLO  = 4'd8;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] pend_hi_q, pend_hi_d;
  logic [31:0] pend_lo_q, pend_lo_d;
  logic        no_commit_q, no_commit_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic               is_md;
  logic               is_div;
  logic               start;
  logic [63:0]        mul_s, mul_u;
  logic [31:0]        div_b;
  logic signed [31:0] a_sd, b_sd;
  logic [31:0]        quot_s, rem_s, quot_u, rem_u;
  logic [31:0]        res_hi, res_lo;

  always_comb begin
    is_md  = (E_MDUOp >= OP_MULT) && (E_MDUOp <= OP_DIVU);
    is_div = (E_MDUOp == OP_DIV) || (E_MDUOp == OP_DIVU);
    start  = is_md && !E_Cancel && (state_q != BUSY);

    mul_s = {{32{E_A[31]}}, E_A} * {{32{E_B[31]}}, E_B};
    mul_u = {32'd0, E_A} * {32'd0, E_B};

    // A zero divisor or the INT_MIN / -1 overflow case divides by 1 instead;
    // the first never commits and the second then yields the wrapped quotient.
    if ((E_B == 32'd0) || ((E_MDUOp == OP_DIV) && (E_A == 32'h8000_0000) && (E_B == 32'hFFFF_FFFF)))
      div_b = 32'd1;
    else
      div_b = E_B;
    a_sd   = E_A;
    b_sd   = div_b;
    quot_s = a_sd / b_sd;
    rem_s  = a_sd % b_sd;
    quot_u = E_A / div_b;
    rem_u  = E_A % div_b;

    res_hi = 32'd0;
    res_lo = 32'd0;
    case (E_MDUOp)
      OP_MULT:  {res_hi, res_lo} = mul_s;
      OP_MULTU: {res_hi, res_lo} = mul_u;
      OP_DIV:   begin res_hi = rem_s; res_lo = quot_s; end
      OP_DIVU:  begin res_hi = rem_u; res_lo = quot_u; end
      default:  begin res_hi = 32'd0; res_lo = 32'd0; end
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pend_hi_d   = pend_hi_q;
    pend_lo_d   = pend_lo_q;
    no_commit_d = no_commit_q;
    hi_d        = hi_q;
    lo_d        = lo_q;

    if (state_q == IDLE) begin
      if (start) begin
        state_d     = BUSY;
        cnt_d       = is_div ? 4'd10 : 4'd5;
        pend_hi_d   = res_hi;
        pend_lo_d   = res_lo;
        no_commit_d = is_div && (E_B == 32'd0);
      end else if (!E_Cancel) begin
        if (E_MDUOp == OP_MTHI) hi_d = E_A;
        if (E_MDUOp == OP_MTLO) lo_d = E_A;
      end
    end else begin
      cnt_d = cnt_q - 4'd1;
      if (cnt_q == 4'd1) begin
        state_d = IDLE;
        if (!no_commit_q) begin
          hi_d = pend_hi_q;
          lo_d = pend_lo_q;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      pend_hi_q   <= 32'd0;
      pend_lo_q   <= 32'd0;
      no_commit_q <= 1'b0;
      hi_q        <= 32'd0;
      lo_q        <= 32'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pend_hi_q   <= pend_hi_d;
      pend_lo_q   <= pend_lo_d;
      no_commit_q <= no_commit_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
    end
  end

  always_comb begin
    E_Busy    = (state_q == BUSY);
    Stall_MDU = D_IsMDU && (E_Busy || (is_md && !E_Cancel));
    HI        = hi_q;
    LO        = lo_q;
    case (E_MDUOp)
      OP_MFHI: E_MDUOut = hi_q;
      OP_MFLO: E_MDUOut = lo_q;
      default: E_MDUOut = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
// tb/tb_mdu_ctrl.sv - directed and scoreboard checks for mdu_ctrl
module tb_mdu_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  E_MDUOp;
  logic [31:0] E_A, E_B;
  logic        E_Cancel, D_IsMDU;
  logic        E_Busy, Stall_MDU;
  logic [31:0] E_MDUOut, HI, LO;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  mdu_ctrl dut (
    .clk      (clk),
    .reset    (reset),
    .E_MDUOp  (E_MDUOp),
    .E_A      (E_A),
    .E_B      (E_B),
    .E_Cancel (E_Cancel),
    .D_IsMDU  (D_IsMDU),
    .E_Busy   (E_Busy),
    .Stall_MDU(Stall_MDU),
    .E_MDUOut (E_MDUOut),
    .HI       (HI),
    .LO       (LO)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] ps;
    logic        [63:0] pu;
    logic signed [31:0] as, bs;
    exp_t r;
    as = a;
    bs = b;
    ps = 64'(as) * 64'(bs);
    pu = {32'd0, a} * {32'd0, b};
    case (op)
      4'd1:    r = ps;
      4'd2:    r = pu;
      4'd3:    begin r.lo = as / bs; r.hi = as % bs; end
      default: begin r.lo = a / b;   r.hi = a % b;   end
    endcase
    return r;
  endfunction

  // Issues op (immediately if imm, else after the next edge), then counts busy cycles and checks the commit.
  task automatic do_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic dis, input bit imm, input int ncyc);
    int   cnt;
    bit   stall_ok;
    exp_t e;
    if (!imm) begin
      @(posedge clk); #1;
    end
    E_MDUOp = op; E_A = a; E_B = b; D_IsMDU = dis; E_Cancel = 1'b0;
    #1;
    chk({tag, "_stall_T"}, 32'(Stall_MDU), 32'(dis));
    chk({tag, "_busy_T"}, 32'(E_Busy), 32'd0);
    @(posedge clk); #1;
    E_MDUOp = 4'd0;
    cnt = 0;
    stall_ok = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (!E_Busy) break;
      cnt++;
      if (Stall_MDU !== dis) stall_ok = 1'b0;
    end
    chk({tag, "_busy_cycles"}, 32'(cnt), 32'(ncyc));
    chk({tag, "_stall_busy"}, 32'(stall_ok), 32'd1);
    chk({tag, "_stall_after"}, 32'(Stall_MDU), 32'd0);
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'(sb.size()), 32'd1);
    end else begin
      e = sb.pop_front();
      chk({tag, "_HI"}, HI, e.hi);
      chk({tag, "_LO"}, LO, e.lo);
    end
  endtask

  task automatic wr(input logic [3:0] op, input logic [31:0] a, input logic cancel);
    @(posedge clk); #1;
    E_MDUOp = op; E_A = a; E_Cancel = cancel;
    @(posedge clk); #1;
    E_MDUOp = 4'd0; E_Cancel = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int          cnt;
    logic [3:0]  op;
    logic [31:0] a, b;

    reset = 1'b1; E_MDUOp = 4'd0; E_A = 32'd0; E_B = 32'd0; E_Cancel = 1'b0; D_IsMDU = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_HI", HI, 32'd0);
    chk("rst_LO", LO, 32'd0);
    chk("rst_busy", 32'(E_Busy), 32'd0);
    chk("rst_stall", 32'(Stall_MDU), 32'd0);
    chk("rst_out", E_MDUOut, 32'd0);

    sb.push_back('{hi: 32'hFFFF_FFFF, lo: 32'hFFFF_FFFE});
    do_op("mult", 4'd1, 32'hFFFF_FFFF, 32'd2, 1'b1, 1'b0, 5);
    sb.push_back('{hi: 32'h0000_0001, lo: 32'hFFFF_FFFE});
    do_op("multu", 4'd2, 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b0, 5);
    sb.push_back('{hi: 32'hFFFF_FFFF, lo: 32'hFFFF_FFFD});
    do_op("div", 4'd3, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0, 10);

    wr(4'd5, 32'h1234, 1'b0);
    wr(4'd6, 32'h5678, 1'b0);
    chk("mthi_HI", HI, 32'h1234);
    chk("mtlo_LO", LO, 32'h5678);
    sb.push_back('{hi: 32'h1234, lo: 32'h5678});
    do_op("divu0", 4'd4, 32'd7, 32'd0, 1'b1, 1'b0, 10);
    E_MDUOp = 4'd7; #1;
    chk("mfhi", E_MDUOut, 32'h1234);
    E_MDUOp = 4'd8; #1;
    chk("mflo", E_MDUOut, 32'h5678);
    E_MDUOp = 4'd9; #1;
    chk("op9_out", E_MDUOut, 32'd0);
    chk("op9_stall", 32'(Stall_MDU), 32'd0);
    E_MDUOp = 4'd0;

    // Cancelled mult and cancelled mthi leave everything untouched.
    @(posedge clk); #1;
    E_MDUOp = 4'd1; E_A = 32'd9; E_B = 32'd9; E_Cancel = 1'b1; D_IsMDU = 1'b1;
    #1 chk("cancel_stall", 32'(Stall_MDU), 32'd0);
    @(posedge clk); #1;
    E_MDUOp = 4'd0; E_Cancel = 1'b0;
    chk("cancel_busy", 32'(E_Busy), 32'd0);
    wr(4'd5, 32'hBAD0, 1'b1);
    repeat (6) @(posedge clk);
    #1;
    chk("cancel_HI", HI, 32'h1234);
    chk("cancel_LO", LO, 32'h5678);

    // Start and mthi presented during busy are ignored.
    D_IsMDU = 1'b0;
    cnt = 0;
    @(posedge clk); #1;
    E_MDUOp = 4'd1; E_A = 32'd3; E_B = 32'd5;
    @(posedge clk); #1;
    E_MDUOp = 4'd4; E_A = 32'd100; E_B = 32'd7; E_Cancel = 1'b1;
    @(negedge clk); if (E_Busy) cnt++;
    @(posedge clk); #1;
    E_MDUOp = 4'd5; E_A = 32'hDEAD; E_Cancel = 1'b0;
    @(negedge clk); if (E_Busy) cnt++;
    @(posedge clk); #1;
    E_MDUOp = 4'd0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (!E_Busy) break;
      cnt++;
    end
    chk("ignore_busy_cycles", 32'(cnt), 32'd5);
    chk("ignore_HI", HI, 32'd0);
    chk("ignore_LO", LO, 32'd15);

    // Back-to-back: second op issued in the first idle cycle after completion.
    sb.push_back('{hi: 32'hFFFF_FFFF, lo: 32'hFFFF_FFF8});
    do_op("b2b_mult", 4'd1, 32'hFFFF_FFFC, 32'd2, 1'b0, 1'b0, 5);
    sb.push_back('{hi: 32'd2, lo: 32'd14});
    do_op("b2b_divu", 4'd4, 32'd100, 32'd7, 1'b0, 1'b1, 10);

    for (int i = 0; i < 4; i++) begin
      op = 4'($urandom_range(1, 4));
      a  = $urandom;
      b  = $urandom;
      if (b == 32'd0) b = 32'd3;
      if (a == 32'h8000_0000) a = 32'h7FFF_0000;
      sb.push_back(model(op, a, b));
      do_op("rand", op, a, b, 1'b1, 1'b0, (op <= 4'd2) ? 5 : 10);
    end

    // Reset in the third busy cycle of a div aborts without commit.
    @(posedge clk); #1;
    E_MDUOp = 4'd3; E_A = 32'd100; E_B = 32'd7;
    @(posedge clk); #1;
    E_MDUOp = 4'd0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("rstmid_busy", 32'(E_Busy), 32'd0);
    chk("rstmid_HI", HI, 32'd0);
    chk("rstmid_LO", LO, 32'd0);
    repeat (12) @(posedge clk);
    #1;
    chk("rstmid_late_busy", 32'(E_Busy), 32'd0);
    chk("rstmid_late_HI", HI, 32'd0);
    chk("rstmid_late_LO", LO, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
